// File: rtl/mem_pkg.sv
// Shared definitions for the memory block copier.
//   - default address/data widths of the 16-bit Memory port
//   - legal range of the read latency parameter
//   - copier FSM state encoding
package mem_pkg;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Address generator for the block copier.
// Owns the word index, the copy direction and the last-word test.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              accepted start: latch src/dst/len, pick direction, init index
//   step              advance the index by one word in the chosen direction
//   src_addr/dst_addr/len  request fields (used only with load)
//   rd_addr           source address for the READ being entered (index after load/step)
//   wr_addr           destination address for the current index
//   last              current index is the final word of the copy
module mem_copy_addr_gen #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic          last
);

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic          desc_q;

  logic [AW:0]   src_ext;
  logic [AW:0]   dst_ext;
  logic [AW:0]   end_ext;
  logic          desc_in;
  logic [AW-1:0] idx_init;
  logic [AW-1:0] idx_step;

  // Overlap test uses one extra bit so src+len never wraps; a range that
  // only overlaps through the wrap therefore copies ascending.
  always_comb begin
    src_ext  = {1'b0, src_addr};
    dst_ext  = {1'b0, dst_addr};
    end_ext  = src_ext + {1'b0, len};
    desc_in  = (dst_ext > src_ext) && (dst_ext < end_ext);
    idx_init = desc_in ? (len - AW'(1)) : '0;
    idx_step = desc_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
  end

  // rd_addr is registered by the top on the edge that enters READ, which is
  // the same edge that loads or steps the index, so it looks one step ahead.
  always_comb begin
    rd_addr = load ? (src_addr + idx_init) : (src_q + idx_step);
    wr_addr = dst_q + idx_q;
    last    = desc_q ? (idx_q == '0) : (idx_q == (len_q - AW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      desc_q <= 1'b0;
    end else if (load) begin
      src_q  <= src_addr;
      dst_q  <= dst_addr;
      len_q  <= len;
      idx_q  <= idx_init;
      desc_q <= desc_in;
    end else if (step) begin
      idx_q  <= idx_step;
    end
  end

endmodule

// File: rtl/mem_block_copier.sv
// Memory block copier (simple DMA, memmove semantics) driving the 16-bit
// Memory port. Each word costs READ (1) + WAIT (RD_LAT) + WRITE (1) cycles.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      one-cycle request, honoured only in IDLE
//   src_addr, dst_addr, len    copy request, latched on accepted start
//   busy, done, count          status: copy in progress, completion pulse, words written
//   mem_addr, mem_data, mem_w, mem_r, mem_q   Memory port (all outputs registered)
//   state                      current FSM state, for observation
// Handshake: start is a request pulse with no ready; it is accepted only when
// the FSM is in IDLE, otherwise dropped. done pulses for exactly one cycle.
// RD_LAT legal range: RD_LAT_MIN..RD_LAT_MAX.
module mem_block_copier
  import mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_w,
  output logic          mem_r,
  input  logic [DW-1:0] mem_q,
  output state_t        state
);

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    wait_q;
  logic          accept;
  logic          step;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          last;

  assign state = state_q;

  mem_copy_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (step),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        if (wait_q == 3'(RD_LAT - 1)) state_d = WRITE;
      end
      WRITE: begin
        if (last) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          step    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= 3'd0;
      mem_r    <= 1'b0;
      mem_w    <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      state_q <= state_d;
      mem_r   <= (state_d == READ);
      mem_w   <= (state_d == WRITE);
      busy    <= (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
      done    <= (state_d == DONE);
      wait_q  <= (state_q == WAIT) ? (wait_q + 3'd1) : 3'd0;

      if (state_d == READ) begin
        mem_addr <= rd_addr;
      end else if (state_d == WRITE) begin
        mem_addr <= wr_addr;
      end

      // mem_data doubles as the word buffer: it captures on the last WAIT cycle.
      if ((state_q == WAIT) && (state_d == WRITE)) begin
        mem_data <= mem_q;
      end

      if (accept) begin
        count <= '0;
      end else if (state_q == WRITE) begin
        count <= count + AW'(1);
      end
    end
  end

endmodule
